// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants and helpers used by the fetch path.
package fetch_unit_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} prefetch queue; the head always lives in slot 0.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [31:0]       push_pc_i,
  input  logic [INST_W-1:0] push_inst_i,
  output logic              valid_o,
  output logic              full_o,
  output logic [31:0]       head_pc_o,
  output logic [INST_W-1:0] head_inst_o
);

  logic [1:0]        r_count;
  logic [31:0]       r_pc0, r_pc1;
  logic [INST_W-1:0] r_inst0, r_inst1;
  logic              w_push, w_pop;

  assign valid_o     = (r_count != 2'd0);
  assign full_o      = (r_count == 2'd2);
  assign head_pc_o   = r_pc0;
  assign head_inst_o = r_inst0;

  assign w_pop  = pop_i && valid_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= 2'd0;
      r_pc0   <= '0;
      r_pc1   <= '0;
      r_inst0 <= '0;
      r_inst1 <= '0;
    end else if (flush_i) begin
      r_count <= 2'd0;
    end else if (w_push && w_pop) begin
      // Count unchanged; new entry lands behind whatever remains.
      if (r_count == 2'd2) begin
        r_pc0   <= r_pc1;
        r_inst0 <= r_inst1;
        r_pc1   <= push_pc_i;
        r_inst1 <= push_inst_i;
      end else begin
        r_pc0   <= push_pc_i;
        r_inst0 <= push_inst_i;
      end
    end else if (w_push) begin
      if (r_count == 2'd0) begin
        r_pc0   <= push_pc_i;
        r_inst0 <= push_inst_i;
      end else begin
        r_pc1   <= push_pc_i;
        r_inst1 <= push_inst_i;
      end
      r_count <= r_count + 2'd1;
    end else if (w_pop) begin
      r_pc0   <= r_pc1;
      r_inst0 <= r_inst1;
      r_count <= r_count - 2'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, redirect handling and a 2-deep prefetch queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_data_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o
);

  logic [31:0] r_pc;
  logic        w_valid, w_full, w_pop, w_push;

  assign imem_addr_o  = r_pc[ADDR_W+1:2];
  assign inst_valid_o = w_valid;

  assign w_pop  = w_valid && inst_ready_i;
  assign w_push = !redirect_i && (!w_full || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= word_align(redirect_pc_i);
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  fetch_fifo u_fetch_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_pc_i   (r_pc),
    .push_inst_i (imem_data_i),
    .valid_o     (w_valid),
    .full_o      (w_full),
    .head_pc_o   (pc_o),
    .head_inst_o (inst_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational word memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst_ni;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  assign imem_data = mem[imem_addr];

  fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .pc_o          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, release it 1ns after that edge.
  task automatic do_reset(input logic ready);
    rst_ni      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = ready;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    #2;
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %0h want 0", inst); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %0h want 0", pc); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h want 1", k, inst_valid); end
      checks++; if (pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got %0h want %0h", k, pc, 4 * k); end
      checks++; if (inst !== 32'(k * 32'h11)) begin errors++; $display("FAIL stream_inst[%0d] got %0h want %0h", k, inst, k * 32'h11); end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%0h pc=%0h inst=%0h want v=1 pc=0 inst=0", k, inst_valid, pc, inst);
      end
      if (k >= 1) begin
        checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL stall_pcr[%0d] got addr %0d want 2", k, imem_addr); end
      end
    end
    inst_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'(4 * k) || inst !== 32'(k * 32'h11)) begin
        errors++; $display("FAIL stall_release[%0d] got v=%0h pc=%0h inst=%0h want v=1 pc=%0h inst=%0h", k, inst_valid, pc, inst, 4 * k, k * 32'h11);
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0023;
    tick();
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got v=%0h want 0", inst_valid); end
    checks++; if (imem_addr !== 6'd8) begin errors++; $display("FAIL redir_addr got %0d want 8", imem_addr); end
    tick();
    checks++; if (inst_valid !== 1'b1 || pc !== 32'h20 || inst !== 32'h88) begin
      errors++; $display("FAIL redir_target got v=%0h pc=%0h inst=%0h want v=1 pc=20 inst=88", inst_valid, pc, inst);
    end
    tick();
    checks++; if (pc !== 32'h20 || inst !== 32'h88) begin errors++; $display("FAIL redir_hold got pc=%0h inst=%0h want pc=20 inst=88", pc, inst); end
  endtask

  task automatic test_redirect_handshake();
    do_reset(1'b1);
    tick(); tick(); tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL hs_pre got pc=%0h want 8", pc); end
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL hs_flush got v=%0h want 0", inst_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'(32'h40 + 4 * k) || inst !== 32'((16 + k) * 32'h11)) begin
        errors++; $display("FAIL hs_after[%0d] got v=%0h pc=%0h inst=%0h want v=1 pc=%0h inst=%0h", k, inst_valid, pc, inst, 32'h40 + 4 * k, (16 + k) * 32'h11);
      end
    end
  endtask

  task automatic test_wrap();
    logic [5:0]  exp_addr [3];
    logic [31:0] exp_pc   [3];
    exp_addr[0] = 6'd0;  exp_addr[1] = 6'd1;  exp_addr[2] = 6'd2;
    exp_pc[0] = 32'hFC;  exp_pc[1] = 32'h100; exp_pc[2] = 32'h104;
    inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_00FC;
    tick();
    redirect = 1'b0;
    checks++; if (imem_addr !== 6'd63) begin errors++; $display("FAIL wrap_addr0 got %0d want 63", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (imem_addr !== exp_addr[k] || pc !== exp_pc[k] || inst !== mem[(63 + k) % 64]) begin
        errors++; $display("FAIL wrap[%0d] got addr=%0d pc=%0h inst=%0h want addr=%0d pc=%0h inst=%0h", k, imem_addr, pc, inst, exp_addr[k], exp_pc[k], mem[(63 + k) % 64]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    tick(); tick(); tick();
    checks++; if (inst_valid !== 1'b1 || imem_addr !== 6'd2) begin errors++; $display("FAIL areset_pre got v=%0h addr=%0d want v=1 addr=2", inst_valid, imem_addr); end
    rst_ni = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h0 || imem_addr !== 6'd0) begin
      errors++; $display("FAIL areset_now got v=%0h pc=%0h inst=%0h addr=%0d want 0 0 0 0", inst_valid, pc, inst, imem_addr);
    end
    #3;
    rst_ni = 1'b1;
    inst_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'(4 * k) || inst !== 32'(k * 32'h11)) begin
        errors++; $display("FAIL areset_refetch[%0d] got v=%0h pc=%0h inst=%0h want v=1 pc=%0h inst=%0h", k, inst_valid, pc, inst, 4 * k, k * 32'h11);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i * 32'h11);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_handshake();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter ADDR_W, default 6, width of the instruction-memory word address.
REQ-003 SHALL have port clk_i, input, 1, sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port imem_addr_o, output, ADDR_W, word address to instruction memory, equal to pc_r[ADDR_W+1:2].
REQ-006 SHALL have port imem_data_i, input, 32, instruction word returned combinationally, same cycle, for imem_addr_o.
REQ-007 SHALL have port redirect_i, input, 1, branch/jump redirect request.
REQ-008 SHALL have port redirect_pc_i, input, 32, redirect target byte address; bits [1:0] ignored, treated as 0.
REQ-009 SHALL have port inst_valid_o, output, 1, head of prefetch queue holds a valid instruction.
REQ-010 SHALL have port inst_ready_i, input, 1, decode accepts the head entry.
REQ-011 SHALL have port inst_o, output, 32, head instruction word.
REQ-012 SHALL have port pc_o, output, 32, byte address of inst_o.

Function
REQ-013 SHALL hold internal pc_r (32 bits) and a 2-entry FIFO of {pc, instr} pairs with a 2-bit occupancy count (0..2).
REQ-014 SHALL drive inst_valid_o = (count != 0); inst_o/pc_o = head entry, driven directly from registers, no combinational path from imem_data_i.
REQ-015 Pop SHALL occur when inst_valid_o && inst_ready_i.
REQ-016 Push SHALL occur when !redirect_i && (count < 2 || pop): entry {pc_r, imem_data_i} written, pc_r <= pc_r + 4.
REQ-017 Simultaneous push and pop SHALL keep count unchanged and preserve FIFO order.
REQ-018 Full (count == 2) with no pop SHALL hold pc_r and FIFO contents unchanged.
REQ-019 inst_o/pc_o SHALL remain stable while inst_valid_o && !inst_ready_i.
REQ-020 Redirect SHALL: clear count to 0, suppress push, set pc_r <= {redirect_pc_i[31:2], 2'b00}; it SHALL take priority over push and pop.
REQ-021 A handshake in the redirect cycle SHALL count as a completed transfer to decode; the FIFO is still flushed.
REQ-022 After a redirect at cycle N, inst_valid_o SHALL be 0 at N+1 and SHALL be 1 at N+2 with pc_o = target.
REQ-023 pc_r SHALL wrap modulo 2^32; imem_addr_o SHALL therefore wrap modulo 2^ADDR_W words (word 63 followed by word 0 at default).
REQ-024 Steady-state throughput SHALL be one instruction per cycle when inst_ready_i is held 1.

Reset
REQ-025 While rst_ni = 0: pc_r = RESET_PC, count = 0, inst_valid_o = 0, inst_o = 0, pc_o = 0, FIFO storage = 0.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronously).
REQ-027 First rising edge with rst_ni = 1 SHALL push RESET_PC; inst_valid_o = 1 after that edge.

Structure
REQ-028 SHALL place RESET_PC default, instruction width 32 and NOP encoding 32'h0000_0013 in the shared CPU package.
REQ-029 SHALL instantiate one sub-module, fetch_fifo (2-entry synchronous FIFO with flush), holding the queue.
REQ-030 SHALL contain no memory array; instruction storage remains in the existing instruction memory.

Verification
REQ-031 Reset release, inst_ready_i = 1, memory words k = k*0x11 -> pc_o 0,4,8,... on consecutive cycles, inst_o 0x00,0x11,0x22,...
REQ-032 inst_ready_i = 0 for 5 cycles after reset -> count saturates at 2, pc_r stays 8, pc_o/inst_o held at 0/word0; release -> pc_o 0,4,8 without gap.
REQ-033 redirect_i with redirect_pc_i = 0x0000_0023 while full -> valid 0 next cycle, then pc_o = 0x20, inst_o = word 8.
REQ-034 Redirect and handshake in the same cycle -> accepted entry consumed once, no stale entry appears afterward.
REQ-035 Redirect to 0xFC, ready held 1 -> imem_addr_o sequence 63, 0, 1; pc_o 0xFC, 0x100, 0x104.
REQ-036 rst_ni pulsed low for half a cycle while count = 2 -> inst_valid_o falls immediately; refetch restarts at RESET_PC.
